// File: rtl/reg_status_file_pkg.sv
// Shared widths and helpers for the architectural register file with rename status.
package reg_status_file_pkg;

  // Mirrors the core's RoB index width (`RoB_addr).
  localparam int unsigned RobAddrDefault = 3;
  localparam int unsigned RegIdW         = 5;
  localparam int unsigned NumRegs        = 32;
  localparam int unsigned DataW          = 32;
  localparam int unsigned CountW         = 6;

  // A write targets a real register only when valid and not x0.
  function automatic logic reg_write_en(input logic valid, input logic [RegIdW-1:0] id);
    return valid && (id != '0);
  endfunction

endpackage

// File: rtl/reg_status_file_read.sv
// One operand read port: selected register state with same-cycle commit bypass.
module reg_status_read
  import reg_status_file_pkg::*;
#(
  parameter int unsigned ROB_ADDR = RobAddrDefault
) (
  input  logic [RegIdW-1:0]   rs_id,
  input  logic                ent_busy,
  input  logic [ROB_ADDR-1:0] ent_tag,
  input  logic [DataW-1:0]    ent_value,
  input  logic                commit_valid,
  input  logic [RegIdW-1:0]   commit_regid,
  input  logic [ROB_ADDR-1:0] commit_rob_idx,
  input  logic [DataW-1:0]    commit_value,
  output logic                rs_busy,
  output logic [ROB_ADDR-1:0] rs_tag,
  output logic [DataW-1:0]    rs_value
);

  // Registered state, overridden by x0 or by a commit that resolves this operand now.
  always_comb begin
    rs_busy  = ent_busy;
    rs_tag   = ent_tag;
    rs_value = ent_value;
    if (rs_id == '0) begin
      rs_busy  = 1'b0;
      rs_tag   = '0;
      rs_value = '0;
    end else if (reg_write_en(commit_valid, commit_regid) && (commit_regid == rs_id) &&
                 ent_busy && (ent_tag == commit_rob_idx)) begin
      rs_busy  = 1'b0;
      rs_value = commit_value;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file x0..x31 with per-register busy/tag rename status.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int unsigned ROB_ADDR = RobAddrDefault
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush_in,
  input  logic                issue_valid,
  input  logic [RegIdW-1:0]   issue_rd,
  input  logic [ROB_ADDR-1:0] issue_rob_idx,
  input  logic                commit_valid,
  input  logic [RegIdW-1:0]   commit_regid,
  input  logic [ROB_ADDR-1:0] commit_rob_idx,
  input  logic [DataW-1:0]    commit_value,
  input  logic [RegIdW-1:0]   rs1_id,
  input  logic [RegIdW-1:0]   rs2_id,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [ROB_ADDR-1:0] rs1_tag,
  output logic [ROB_ADDR-1:0] rs2_tag,
  output logic [DataW-1:0]    rs1_value,
  output logic [DataW-1:0]    rs2_value,
  output logic [CountW-1:0]   busy_count
);

  logic [DataW-1:0]    value_q [NumRegs];
  logic [DataW-1:0]    value_d [NumRegs];
  logic [ROB_ADDR-1:0] tag_q   [NumRegs];
  logic [ROB_ADDR-1:0] tag_d   [NumRegs];
  logic [NumRegs-1:0]  busy_q, busy_d;
  logic [CountW-1:0]   busy_count_q, busy_count_d;

  logic commit_hit, commit_clr, issue_hit, flush_hit, cnt_inc, cnt_dec;

  assign commit_hit = rdy_in && reg_write_en(commit_valid, commit_regid);
  assign commit_clr = commit_hit && (tag_q[commit_regid] == commit_rob_idx);
  assign flush_hit  = rdy_in && flush_in;
  // A flush drops the concurrent issue.
  assign issue_hit  = rdy_in && !flush_in && reg_write_en(issue_valid, issue_rd);
  // Counter steps only on real 0->1 / 1->0 transitions; same-register commit+issue stays busy.
  assign cnt_inc    = issue_hit && !busy_q[issue_rd];
  assign cnt_dec    = commit_clr && busy_q[commit_regid] &&
                      !(issue_hit && (issue_rd == commit_regid));

  // Next-state: commit writes value, issue/flush override busy and tag.
  always_comb begin
    value_d      = value_q;
    tag_d        = tag_q;
    busy_d       = busy_q;
    busy_count_d = busy_count_q;
    if (commit_hit) begin
      value_d[commit_regid] = commit_value;
    end
    if (commit_clr) begin
      busy_d[commit_regid] = 1'b0;
    end
    if (flush_hit) begin
      busy_d = '0;
    end else if (issue_hit) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rob_idx;
    end
    if (flush_hit) begin
      busy_count_d = '0;
    end else if (cnt_inc && !cnt_dec) begin
      busy_count_d = busy_count_q + CountW'(1);
    end else if (cnt_dec && !cnt_inc) begin
      busy_count_d = busy_count_q - CountW'(1);
    end
  end

  // State registers; x0 entries are never written so they stay zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NumRegs; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      value_q      <= value_d;
      tag_q        <= tag_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  reg_status_read #(.ROB_ADDR(ROB_ADDR)) u_read_rs1 (
    .rs_id          (rs1_id),
    .ent_busy       (busy_q[rs1_id]),
    .ent_tag        (tag_q[rs1_id]),
    .ent_value      (value_q[rs1_id]),
    .commit_valid   (commit_valid),
    .commit_regid   (commit_regid),
    .commit_rob_idx (commit_rob_idx),
    .commit_value   (commit_value),
    .rs_busy        (rs1_busy),
    .rs_tag         (rs1_tag),
    .rs_value       (rs1_value)
  );

  reg_status_read #(.ROB_ADDR(ROB_ADDR)) u_read_rs2 (
    .rs_id          (rs2_id),
    .ent_busy       (busy_q[rs2_id]),
    .ent_tag        (tag_q[rs2_id]),
    .ent_value      (value_q[rs2_id]),
    .commit_valid   (commit_valid),
    .commit_regid   (commit_regid),
    .commit_rob_idx (commit_rob_idx),
    .commit_value   (commit_value),
    .rs_busy        (rs2_busy),
    .rs_tag         (rs2_tag),
    .rs_value       (rs2_value)
  );

endmodule
